freq_tuning_estimator: RTL and testbench
========================================

FREQ_TUNING_ESTIMATOR -- requirements
Module: freq_tuning_estimator

Interface
REQ-001 SHALL have parameter n, default 23, meaning the gate window is 2^n clk cycles (equal to the phase accumulator width).
REQ-002 SHALL have parameter tune, default 16, meaning the tuning-word width.
REQ-003 SHALL have parameter CONT, default 0, meaning 1 re-arms automatically after each measurement.
REQ-004 SHALL have port clk, input, 1 bit, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, meaning the asynchronous, active-high reset.
REQ-006 SHALL have port sig_in, input, 1 bit, meaning the asynchronous square wave under test (e.g. phase MSB).
REQ-007 SHALL have port start, input, 1 bit, meaning a one-cycle request to begin a measurement.
REQ-008 SHALL have port tuning_est, output, tune bits, meaning the recovered tuning word, held until the next result.
REQ-009 SHALL have port valid, output, 1 bit, meaning a one-cycle pulse when tuning_est updates.
REQ-010 SHALL have port busy, output, 1 bit, meaning high while the gate window is open.
REQ-011 SHALL have port overflow, output, 1 bit, meaning the last result saturated; held with tuning_est.

Function
REQ-012 SHALL pass sig_in through a 2-flop synchronizer, then a registered edge detector (rising edges only), giving a 3-cycle input latency.
REQ-013 SHALL implement states IDLE, COUNT and DONE.
REQ-014 SHALL move IDLE->COUNT on start=1 (or immediately when CONT=1), clearing the window counter and edge counter.
REQ-015 SHALL stay in COUNT for exactly 2^n cycles, counting one per detected rising edge in each of those cycles, then go COUNT->DONE.
REQ-016 SHALL make DONE last one cycle: load tuning_est/overflow, pulse valid, go to IDLE (CONT=0) or COUNT with cleared counters (CONT=1).
REQ-017 SHALL assert busy exactly in COUNT.
REQ-018 SHALL use a (tune+1)-bit edge counter that saturates at 2^tune; overflow=1 and tuning_est=all-ones if the count reaches 2^tune, else tuning_est=count and overflow=0.
REQ-019 SHALL count an edge detected in the final COUNT cycle; an edge detected in DONE is not counted.
REQ-020 SHALL ignore start in COUNT and DONE (no restart, no queueing).
REQ-021 SHALL treat start when CONT=1 as don't-care.
REQ-022 SHALL make the window counter n bits wide and detect its terminal count at all-ones, with no extra wrap cycle.
REQ-023 SHALL make the result equal the tuning word of a matching accumulator running on the same clk: count = f*2^n/fclk.

Reset
REQ-024 SHALL, on rst=1 (asynchronous, any state, including mid-window), go to IDLE and set tuning_est=0, valid=0, busy=0, overflow=0, all counters=0 and synchronizer flops=0.
REQ-025 SHALL, after rst deasserts, not count an edge until a 0->1 transition is seen through the synchronizer; CONT=1 starts counting on the first cycle after release.

Structure
REQ-026 SHALL keep the state enum and the defaults for n/tune in shared package dds_pkg.
REQ-027 SHALL have one sub-module sync_edge_detect (2-flop sync plus rise pulse, async reset).

Verification (bench parameters n=10, tune=8, CONT=0 unless stated)
REQ-028 SHALL cover: sig_in period 16 clk, start pulse -> busy high 1024 cycles, then valid one cycle with tuning_est=64, overflow=0.
REQ-029 SHALL cover: sig_in held 0, start -> tuning_est=0, valid after 1025 cycles; sig_in period 2 clk -> count 512 saturates -> tuning_est=255, overflow=1.
REQ-030 SHALL cover: a matching accumulator (n=10, tuning=37) with its MSB driving sig_in -> tuning_est in {36,37,38}.
REQ-031 SHALL cover: start re-pulsed at window cycle 500 -> ignored; valid still at the original cycle 1025.
REQ-032 SHALL cover: rst pulsed at window cycle 300 -> all outputs 0 immediately, state IDLE, no valid; a fresh start then yields 64 for period 16.
REQ-033 SHALL cover: CONT=1, period 16 -> valid every 1025 cycles, each with tuning_est=64, busy low only in DONE cycles.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS frequency/tuning-word estimator:
// FSM state encoding and default widths.
package dds_pkg;

    localparam int N_DEFAULT    = 23;
    localparam int TUNE_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input followed by a registered
// rising-edge pulse; the pulse appears three clocks after the input changes.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
        end
    end

endmodule

// File: rtl/freq_tuning_estimator.sv
// Counts rising edges of an asynchronous square wave over a 2^n-cycle gate
// window; the count equals the tuning word of a matching n-bit accumulator.
module freq_tuning_estimator
    import dds_pkg::*;
#(
    parameter int n    = N_DEFAULT,
    parameter int tune = TUNE_DEFAULT,
    parameter bit CONT = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sig_in,
    input  logic            start,
    output logic [tune-1:0] tuning_est,
    output logic            valid,
    output logic            busy,
    output logic            overflow
);

    localparam logic [n-1:0] WIN_ONE  = 1;
    localparam logic [tune:0] EDGE_ONE = 1;

    state_t        state;
    logic [n-1:0]  win;
    logic [tune:0] edges;
    logic          rise;

    sync_edge_detect u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sig_in),
        .rise (rise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            win        <= '0;
            edges      <= '0;
            tuning_est <= '0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start || CONT) begin
                        state <= COUNT;
                        win   <= '0;
                        edges <= '0;
                        busy  <= 1'b1;
                    end
                end
                COUNT: begin
                    // The MSB of the edge counter doubles as the saturation flag.
                    if (rise && !edges[tune]) begin
                        edges <= edges + EDGE_ONE;
                    end
                    if (win == '1) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end else begin
                        win <= win + WIN_ONE;
                    end
                end
                DONE: begin
                    valid      <= 1'b1;
                    overflow   <= edges[tune];
                    tuning_est <= edges[tune] ? '1 : edges[tune-1:0];
                    if (CONT) begin
                        state <= COUNT;
                        win   <= '0;
                        edges <= '0;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_tuning_estimator.sv
// Bench for freq_tuning_estimator (n=10, tune=8): one single-shot instance
// and one continuous instance, driven by a phase-accumulator square wave.
module tb_freq_tuning_estimator;
    import dds_pkg::*;

    localparam int N    = 10;
    localparam int TUNE = 8;
    localparam int WIN  = 1 << N;
    localparam int HMAX = 40000;

    logic            clk = 1'b0;
    logic            rst;
    logic            rst_c;
    logic            sig_in;
    logic            start;
    logic [TUNE-1:0] tuning_est;
    logic            valid;
    logic            busy;
    logic            overflow;
    logic [TUNE-1:0] tuning_est_c;
    logic            valid_c;
    logic            busy_c;
    logic            overflow_c;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    bit hist[0:HMAX-1];
    int inc = 0;
    int ph0 = 0;

    freq_tuning_estimator #(.n(N), .tune(TUNE), .CONT(1'b0)) dut (
        .clk(clk), .rst(rst), .sig_in(sig_in), .start(start),
        .tuning_est(tuning_est), .valid(valid), .busy(busy), .overflow(overflow)
    );

    freq_tuning_estimator #(.n(N), .tune(TUNE), .CONT(1'b1)) dut_c (
        .clk(clk), .rst(rst_c), .sig_in(sig_in), .start(start),
        .tuning_est(tuning_est_c), .valid(valid_c), .busy(busy_c), .overflow(overflow_c)
    );

    // clock / reset-free infrastructure
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cyc < HMAX) hist[cyc] = sig_in;
        cyc++;
    end

    // square wave = MSB of an accumulator with phase offset ph0 and step inc
    initial begin : wave_driver
        int unsigned kk;
        logic [N-1:0] acc;
        kk = 0;
        sig_in = 1'b0;
        forever begin
            @(negedge clk);
            acc = N'(ph0 + inc * int'(kk));
            sig_in = acc[N-1];
            kk++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Rising transitions of the sampled input whose first high sample lands
    // in the slice the gate window sees, given the 3-cycle input latency.
    function automatic int model_count(input int s);
        int c = 0;
        for (int t = s - 2; t <= s + WIN - 3; t++) begin
            if (t >= 1 && t < HMAX && hist[t] && !hist[t-1]) c++;
        end
        return c;
    endfunction

    task automatic set_wave(input int i, input int p);
        inc = i;
        ph0 = p;
        repeat (4) @(negedge clk);
    endtask

    task automatic measure(input string tag, input bit repulse, input int fixed_exp);
        int s;
        int busy_cnt;
        int vj;
        int c;
        logic [TUNE-1:0] e_est;
        logic e_ovf;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        s = cyc - 1;
        busy_cnt = int'(busy);
        vj = 0;
        @(negedge clk);
        start = 1'b0;
        for (int j = 1; j <= 1100; j++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                vj = j;
                break;
            end
            busy_cnt += int'(busy);
            if (repulse && j == 499) start = 1'b1;
            if (repulse && j == 500) start = 1'b0;
        end
        chk({tag, "_latency"}, vj, WIN + 1);
        chk({tag, "_busy_cycles"}, busy_cnt, WIN);
        if (vj != 0) begin
            c = model_count(s);
            e_ovf = (c >= (1 << TUNE));
            e_est = e_ovf ? {TUNE{1'b1}} : TUNE'(c);
            chk({tag, "_est"}, tuning_est, e_est);
            chk({tag, "_ovf"}, overflow, e_ovf);
            if (fixed_exp >= 0) chk({tag, "_est_fixed"}, tuning_est, fixed_exp);
            @(posedge clk);
            #1;
            chk({tag, "_valid_one_cycle"}, valid, 0);
        end
    endtask

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : main
        int s;
        int busy_low;
        int vj;
        int c;
        rst = 1'b1;
        rst_c = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_est", tuning_est, 0);
        chk("reset_valid", valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ovf", overflow, 0);
        chk("reset_state", 32'(dut.state), 32'(IDLE));
        rst = 1'b0;

        set_wave(64, 0);
        measure("period16", 1'b0, 64);

        set_wave(0, 0);
        measure("held0", 1'b0, 0);

        set_wave(512, 0);
        measure("period2_sat", 1'b0, 255);

        set_wave(37, int'($urandom_range(0, 1023)));
        measure("acc37", 1'b0, -1);
        chk("acc37_range", 32'((tuning_est >= 36) && (tuning_est <= 38)), 1);

        set_wave(64, int'($urandom_range(0, 1023)));
        measure("restart_ignored", 1'b1, 64);

        // asynchronous reset in the middle of a window
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        chk("midrst_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        chk("midrst_est", tuning_est, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ovf", overflow, 0);
        chk("midrst_state", 32'(dut.state), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        c = 0;
        repeat (1100) begin
            @(posedge clk);
            #1;
            c += int'(valid);
        end
        chk("midrst_no_valid", c, 0);
        measure("after_rst", 1'b0, 64);

        for (int k = 0; k < 4; k++) begin
            set_wave(int'($urandom_range(1, 600)), int'($urandom_range(0, 1023)));
            measure("random", 1'b0, -1);
        end

        // continuous mode
        set_wave(64, int'($urandom_range(0, 1023)));
        @(negedge clk);
        rst_c = 1'b0;
        @(posedge clk);
        #1;
        s = cyc - 1;
        chk("cont_busy_first", busy_c, 1);
        for (int w = 0; w < 3; w++) begin
            busy_low = 0;
            vj = 0;
            for (int j = 1; j <= 1100; j++) begin
                @(posedge clk);
                #1;
                if (valid_c) begin
                    vj = j;
                    break;
                end
                if (!busy_c) busy_low++;
            end
            chk("cont_latency", vj, WIN + 1);
            chk("cont_busy_low", busy_low, 1);
            chk("cont_busy_rearm", busy_c, 1);
            chk("cont_est", tuning_est_c, 64);
            chk("cont_est_model", tuning_est_c, model_count(s));
            chk("cont_ovf", overflow_c, 0);
            s = s + WIN + 1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
